// File: rtl/dm_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: access width codes,
// FSM state type, default DM size and the alignment helper.
package dm_port_arbiter_pkg;

    localparam int DM_AW_DEF = 12;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_BYTE = 2'b10;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    // Alignment of a byte address for a given width; the illegal code is never aligned.
    function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] lsb);
        logic res;
        case (width)
            WIDTH_WORD: res = (lsb == 2'b00);
            WIDTH_HALF: res = ~lsb[0];
            WIDTH_BYTE: res = 1'b1;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: with both requesting, the port that was not
// granted last wins; otherwise the lone requester wins.
module dm_port_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       any
);

    // Pick the winner combinationally from the eligible requests.
    always_comb begin
        any    = |req;
        gnt_id = 1'b0;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single data memory between the CPU MEM stage (port 0) and the
// loader/DMA (port 1). One DM transaction per grant, illegal accesses are
// acknowledged with err and never reach the memory as a write.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | no access in flight; arbitrate eligible requests
// S_ACCESS | cur port drives the DM for exactly one cycle
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int DM_AW  = DM_AW_DEF,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_width,
    input  logic              p0_load_sign,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [31:0]       p0_pc,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [31:0]       p0_rdata,
    output logic              p0_stall,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_width,
    input  logic              p1_load_sign,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [31:0]       p1_pc,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [31:0]       p1_rdata,
    output logic              dm_we,
    output logic [1:0]        dm_width,
    output logic              dm_load_sign,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wd,
    output logic [31:0]       dm_pc,
    input  logic [31:0]       dm_rd
);

    state_e            state_q, state_d;
    logic              cur_q, cur_d;
    logic              last_gnt_q, last_gnt_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;

    logic [1:0]        elig;
    logic              gnt_id;
    logic              any;
    logic              cur_we;
    logic [1:0]        cur_width;
    logic              cur_sign;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [31:0]       cur_pc;
    logic              ok;
    logic [31:0]       resp;

    // A port being acked this cycle still shows its old request, so it sits out.
    assign elig = {p1_req & ~ack_q[1], p0_req & ~ack_q[0]};

    dm_port_arbiter_rr_arb2 u_rr (
        .req    (elig),
        .last   (last_gnt_q),
        .gnt_id (gnt_id),
        .any    (any)
    );

    // Route the current owner's fields to the DM and judge legality.
    always_comb begin
        cur_we    = cur_q ? p1_we        : p0_we;
        cur_width = cur_q ? p1_width     : p0_width;
        cur_sign  = cur_q ? p1_load_sign : p0_load_sign;
        cur_addr  = cur_q ? p1_addr      : p0_addr;
        cur_wdata = cur_q ? p1_wdata     : p0_wdata;
        cur_pc    = cur_q ? p1_pc        : p0_pc;
        ok        = is_aligned(cur_width, cur_addr[1:0]) &&
                    ((cur_addr >> (DM_AW + 2)) == '0);
        resp      = (~cur_we & ok) ? dm_rd : 32'h0;
    end

    // Reset gates the write in the same cycle so a store cut short never lands.
    assign dm_we        = (state_q == S_ACCESS) & cur_we & ok & ~reset;
    assign dm_width     = cur_width;
    assign dm_load_sign = cur_sign;
    assign dm_addr      = cur_addr;
    assign dm_wd        = cur_wdata;
    assign dm_pc        = cur_pc;

    // Next-state, grant latching and response generation.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_gnt_d = last_gnt_q;
        ack_d      = 2'b00;
        err_d      = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (any) begin
                    state_d    = S_ACCESS;
                    cur_d      = gnt_id;
                    last_gnt_d = gnt_id;
                end
            end
            S_ACCESS: begin
                state_d       = S_IDLE;
                ack_d[cur_q]  = 1'b1;
                err_d[cur_q]  = ~ok;
                if (cur_q) begin
                    rdata1_d = resp;
                end else begin
                    rdata0_d = resp;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers; last_gnt resets to 1 so port 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            ack_q      <= 2'b00;
            err_q      <= 2'b00;
            rdata0_q   <= 32'h0;
            rdata1_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_gnt_q <= last_gnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p0_err   = err_q[0];
    assign p1_err   = err_q[1];
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;
    assign p0_stall = p0_req & ~ack_q[0];

endmodule
